// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit lookahead slice per stage,
// a single global enable stalls every stage together under output backpressure.
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int BLK_S = (BLK < 1) ? 1 : BLK;
    localparam int NSTG  = WIDTH / BLK_S;

    if ((BLK < 1) || ((WIDTH % BLK_S) != 0) || (NSTG < 1)) begin : g_bad_param
        $error("cla_pipe_adder: WIDTH must be a positive multiple of BLK");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = cin ^ sub;

    // Stage k consumes the low BLK bits of what is left of the operands and
    // forwards only the still-unused upper bits, so operand storage shrinks per stage.
    for (genvar k = 0; k < NSTG; k++) begin : stg
        localparam int IW = WIDTH - k * BLK_S;
        localparam int DW = (k + 1) * BLK_S;

        logic [IW-1:0]    a_in;
        logic [IW-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic [DW-1:0]    s_nx;
        logic [BLK_S-1:0] p;
        logic [BLK_S-1:0] g;
        logic [BLK_S-1:0] s_sl;
        logic [BLK_S:0]   c;
        logic             v_q;
        logic             c_q;
        logic [DW-1:0]    s_q;

        if (k == 0) begin : g_src
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = c_eff;
            assign v_in = in_valid && in_ready;
            assign s_nx = s_sl;
        end else begin : g_src
            assign a_in = stg[k-1].g_op.a_q;
            assign b_in = stg[k-1].g_op.b_q;
            assign c_in = stg[k-1].c_q;
            assign v_in = stg[k-1].v_q;
            assign s_nx = {s_sl, stg[k-1].s_q};
        end

        assign p = a_in[BLK_S-1:0] ^ b_in[BLK_S-1:0];
        assign g = a_in[BLK_S-1:0] & b_in[BLK_S-1:0];

        always_comb begin
            c    = '0;
            c[0] = c_in;
            for (int i = 0; i < BLK_S; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
        end

        assign s_sl = p ^ c[BLK_S-1:0];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= c[BLK_S];
                s_q <= s_nx;
            end
        end

        if (k < NSTG - 1) begin : g_op
            logic [IW-BLK_S-1:0] a_q;
            logic [IW-BLK_S-1:0] b_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    a_q <= a_in[IW-1:BLK_S];
                    b_q <= b_in[IW-1:BLK_S];
                end
            end
        end

        // Only the final slice holds the MSB, so overflow is formed there alone.
        if (k == NSTG - 1) begin : g_last
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c[BLK_S] ^ c[BLK_S-1];
                end
            end
        end
    end

    assign out_valid = stg[NSTG-1].v_q;
    assign sum       = stg[NSTG-1].s_q;
    assign cout      = stg[NSTG-1].c_q;
    assign ovf       = stg[NSTG-1].g_last.ovf_q;

endmodule
